reg_op_sequencer: RTL and testbench

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_reg_op_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer
//   Queues register commands {op, data, count} in a small FIFO and replays each
//   one to a downstream 4-bit register as count+1 consecutive enabled cycles.
//
//   Optional build macro: REG_OP_SEQUENCER_SHADOW_EN adds shadow_q, a local
//   model of the downstream register.
//
// Parameters
//   DEPTH      command FIFO depth in entries (power of two, 2..16)
// Ports
//   clk        clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   cmd_valid  command offered this cycle
//   cmd_ready  FIFO not full
//   cmd_op     00 clear, 01 load, 10 decrement, 11 increment
//   cmd_data   load value
//   cmd_count  repeat count (op applied cmd_count+1 cycles)
//   abort      flush FIFO and stop the current command
//   FunSel     function select to the downstream register
//   data_out   load data to the downstream register
//   enable     downstream register enable
//   busy       command running/emitting or FIFO non-empty
//   done       pulse on the final enabled cycle of a command
//   shadow_q   (SHADOW_EN only) model of the downstream register
module reg_op_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [3:0] cmd_count,
  input  logic       abort,
  output logic [1:0] FunSel,
  output logic [3:0] data_out,
  output logic       enable,
  output logic       busy,
  output logic       done
`ifdef REG_OP_SEQUENCER_SHADOW_EN
  ,
  output logic [3:0] shadow_q
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] count;
  } cmd_t;

  // ---------------- command FIFO ----------------
  cmd_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  cmd_t        head;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [3:0]  wdata_q;
  logic [3:0]  cnt_q;
  logic [1:0]  fun_sel_q;
  logic [3:0]  data_out_q;
  logic        en_q;
  logic        done_q;

  // Extra MSB on the pointers separates full (MSBs differ) from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full && !abort;
  assign pop   = (state_q == IDLE) && !empty && !abort;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{op: cmd_op, data: cmd_data, count: cmd_count};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_INC;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_INC;
    end
  end

  // ---------------- sequencer FSM ----------------
  // Outputs are registered from the RUN state, so the enabled window lags the
  // RUN state by one cycle: pop at edge N+1, first enable after edge N+2, and
  // the pop for a following command lands on the final-enable cycle, leaving
  // exactly one enable-low cycle between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      fun_sel_q  <= '0;
      data_out_q <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          en_q   <= 1'b0;
          done_q <= 1'b0;
          if (!empty) begin
            op_q    <= head.op;
            wdata_q <= head.data;
            cnt_q   <= head.count;
            state_q <= RUN;
          end
        end
        RUN: begin
          en_q       <= 1'b1;
          fun_sel_q  <= op_q;
          data_out_q <= wdata_q;
          if (cnt_q == 4'd0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = !full;
  assign FunSel    = fun_sel_q;
  assign data_out  = data_out_q;
  assign enable    = en_q;
  assign done      = done_q;
  // en_q keeps busy high through the last emitted cycle after the FSM has
  // already returned to IDLE.
  assign busy      = (state_q == RUN) || !empty || en_q;

`ifdef REG_OP_SEQUENCER_SHADOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (en_q) begin
      case (fun_sel_q)
        2'b00:   shadow_q <= '0;
        2'b01:   shadow_q <= data_out_q;
        2'b10:   shadow_q <= shadow_q - 4'd1;
        default: shadow_q <= shadow_q + 4'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
module tb_reg_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_count;
  logic       abort;
  logic [1:0] FunSel;
  logic [3:0] data_out;
  logic       enable;
  logic       busy;
  logic       done;
`ifdef REG_OP_SEQUENCER_SHADOW_EN
  logic [3:0] shadow_q;
  logic [3:0] sh_model;
`endif

  reg_op_sequencer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .abort     (abort),
    .FunSel    (FunSel),
    .data_out  (data_out),
    .enable    (enable),
    .busy      (busy),
    .done      (done)
`ifdef REG_OP_SEQUENCER_SHADOW_EN
    ,
    .shadow_q  (shadow_q)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks  = 0;
  int unsigned n_fail    = 0;
  int unsigned done_seen = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic       done;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  data;
    logic [3:0]  count;
    int unsigned exp_cycles;
    logic [3:0]  exp_shadow;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

`ifdef REG_OP_SEQUENCER_SHADOW_EN
  function automatic logic [3:0] reg_next(input logic [3:0] cur, input logic [1:0] op,
                                          input logic [3:0] d);
    case (op)
      2'b00:   return 4'h0;
      2'b01:   return d;
      2'b10:   return cur - 4'd1;
      default: return cur + 4'd1;
    endcase
  endfunction
`endif

  // Scoreboard: every enabled cycle must match the next expected entry.
  always @(negedge clk) begin
    if (!rst_n) begin
`ifdef REG_OP_SEQUENCER_SHADOW_EN
      sh_model = '0;
`endif
    end else begin
`ifdef REG_OP_SEQUENCER_SHADOW_EN
      check("shadow_q", 32'(shadow_q), 32'(sh_model));
`endif
      check("done_implies_enable", 32'(done & ~enable), 32'd0);
      if (enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_enable", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("FunSel", 32'(FunSel), 32'(mon_e.op));
          check("data_out", 32'(data_out), 32'(mon_e.data));
          check("done", 32'(done), 32'(mon_e.done));
`ifdef REG_OP_SEQUENCER_SHADOW_EN
          sh_model = reg_next(sh_model, mon_e.op, mon_e.data);
`endif
        end
        if (done) done_seen++;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic push_cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] c);
    int unsigned waited = 0;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!cmd_ready) begin
      check("push_accept_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      for (int unsigned k = 0; k <= 32'(c); k++) exp_q.push_back('{op, d, (k == 32'(c))});
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Number of negedges before the first one with enable high.
  task automatic wait_enable(output int unsigned lat);
    lat = 999;
    for (int unsigned k = 0; k < 60; k++) begin
      @(negedge clk);
      if (enable) begin
        lat = k;
        return;
      end
    end
    check("wait_enable_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_enable(output int unsigned cnt);
    cnt = 1;
    for (int unsigned k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!enable) return;
      cnt++;
    end
  endtask

  task automatic wait_idle();
    for (int unsigned k = 0; k < 200; k++) begin
      if (!busy) return;
      @(posedge clk);
      #1;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    int unsigned cnt;
    int unsigned done0;
    logic [7:0]  pat;

    vecs[0] = '{2'b01, 4'b1010, 4'd0,  1,  4'b1010};
    vecs[1] = '{2'b11, 4'b0000, 4'd3,  4,  4'b1110};
    vecs[2] = '{2'b10, 4'b0101, 4'd1,  2,  4'b1100};
    vecs[3] = '{2'b01, 4'b1111, 4'd0,  1,  4'b1111};
    vecs[4] = '{2'b11, 4'b0110, 4'd0,  1,  4'b0000};
    vecs[5] = '{2'b00, 4'b0011, 4'd0,  1,  4'b0000};
    vecs[6] = '{2'b10, 4'b1000, 4'd0,  1,  4'b1111};
    vecs[7] = '{2'b11, 4'b1001, 4'd15, 16, 4'b1111};
    vecs[8] = '{2'b00, 4'b0110, 4'd2,  3,  4'b0000};

    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_op = '0; cmd_data = '0; cmd_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_FunSel", 32'(FunSel), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
`ifdef REG_OP_SEQUENCER_SHADOW_EN
    check("rst_shadow", 32'(shadow_q), 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single commands into an idle block.
    for (int i = 0; i < 9; i++) begin
      push_cmd(vecs[i].op, vecs[i].data, vecs[i].count);
      wait_enable(lat);
      check("first_enable_latency", lat, 32'd2);
      count_enable(cnt);
      check("enable_cycles", cnt, vecs[i].exp_cycles);
`ifdef REG_OP_SEQUENCER_SHADOW_EN
      check("vec_shadow", 32'(shadow_q), 32'(vecs[i].exp_shadow));
`endif
      @(posedge clk);
      #1;
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Back-to-back: 4x increment, one gap cycle, 2x decrement.
    push_cmd(2'b11, 4'b0000, 4'd3);
    push_cmd(2'b10, 4'b0000, 4'd1);
    wait_enable(lat);
    pat[7] = enable;
    for (int j = 6; j >= 0; j--) begin
      @(negedge clk);
      pat[j] = enable;
    end
    check("b2b_enable_pattern", 32'(pat), 32'h000000F6);
`ifdef REG_OP_SEQUENCER_SHADOW_EN
    check("b2b_shadow", 32'(shadow_q), 32'h2);
`endif
    @(posedge clk);
    #1;

    // FIFO fills behind a long command; fifth push waits for a pop.
    done0 = done_seen;
    push_cmd(2'b11, 4'b0000, 4'd15);
    wait_enable(lat);
    @(posedge clk);
    #1;
    push_cmd(2'b01, 4'b0011, 4'd0);
    push_cmd(2'b11, 4'b0000, 4'd1);
    push_cmd(2'b10, 4'b0000, 4'd0);
    push_cmd(2'b00, 4'b0000, 4'd0);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    push_cmd(2'b01, 4'b0101, 4'd1);
    check("fifth_after_pop", done_seen - done0, 32'd1);
    wait_idle();
    check("full_queue_drained", exp_q.size(), 32'd0);
    check("full_done_count", done_seen - done0, 32'd6);

    // Abort in the 3rd cycle of a count=7 command with two queued; a push
    // offered on the abort edge is dropped.
    push_cmd(2'b11, 4'b0000, 4'd7);
    push_cmd(2'b01, 4'b1100, 4'd0);
    push_cmd(2'b10, 4'b0000, 4'd2);
    done0 = done_seen;
    wait_enable(lat);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    cmd_op = 2'b01; cmd_data = 4'b0001; cmd_count = 4'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    check("abort_enable", 32'(enable), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("abort_still_idle", 32'(busy), 32'd0);
    check("abort_no_done", done_seen - done0, 32'd0);

    // Asynchronous reset mid-RUN with two queued.
    push_cmd(2'b01, 4'b0111, 4'd7);
    push_cmd(2'b11, 4'b0000, 4'd0);
    push_cmd(2'b10, 4'b0000, 4'd0);
    wait_enable(lat);
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
`ifdef REG_OP_SEQUENCER_SHADOW_EN
    sh_model = '0;
`endif
    #1;
    check("areset_enable", 32'(enable), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("areset_FunSel", 32'(FunSel), 32'd0);
    check("areset_data_out", 32'(data_out), 32'd0);
`ifdef REG_OP_SEQUENCER_SHADOW_EN
    check("areset_shadow", 32'(shadow_q), 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("areset_queue_discarded", 32'(busy), 32'd0);

    push_cmd(2'b01, 4'b1001, 4'd0);
    wait_enable(lat);
    check("post_reset_latency", lat, 32'd2);
    @(posedge clk);
    #1;
    wait_idle();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
